// File: rtl/alu_arbiter_if.sv
// ============================================================================
// Module      : alu_arbiter_if
// Description : Request, ALU-drive and response bundle between two requesters,
//               the shared ALU and the alu_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_arbiter_if #(
    parameter int WORDSIZE = 64
);
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [WORDSIZE-1:0] req_a0;
    logic [WORDSIZE-1:0] req_a1;
    logic [WORDSIZE-1:0] req_b0;
    logic [WORDSIZE-1:0] req_b1;
    logic [5:0]          req_funct3;   // {r1, r0}
    logic [1:0]          req_funct7;

    logic [WORDSIZE-1:0] alu_a;
    logic [WORDSIZE-1:0] alu_b;
    logic [2:0]          alu_funct3;
    logic                alu_funct7;
    logic [WORDSIZE-1:0] alu_result;
    logic [3:0]          alu_flags;    // {extra, overflow, msb, zero}

    logic [1:0]          rsp_valid;
    logic [1:0]          rsp_ready;
    logic [WORDSIZE-1:0] rsp_result;
    logic [3:0]          rsp_flags;
    logic                busy;

    modport master (
        output req_valid, req_a0, req_a1, req_b0, req_b1, req_funct3, req_funct7,
        output alu_result, alu_flags, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_funct3, alu_funct7,
        input  rsp_valid, rsp_result, rsp_flags, busy
    );

    modport slave (
        input  req_valid, req_a0, req_a1, req_b0, req_b1, req_funct3, req_funct7,
        input  alu_result, alu_flags, rsp_ready,
        output req_ready, alu_a, alu_b, alu_funct3, alu_funct7,
        output rsp_valid, rsp_result, rsp_flags, busy
    );
endinterface

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin sharing of one 64-bit ALU between two requesters,
//               with registered operands and a captured result/flag response.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter #(
    parameter int WORDSIZE = 64
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                grant_id_q, grant_id_d;
    logic [WORDSIZE-1:0] alu_a_q, alu_a_d;
    logic [WORDSIZE-1:0] alu_b_q, alu_b_d;
    logic [2:0]          alu_funct3_q, alu_funct3_d;
    logic                alu_funct7_q, alu_funct7_d;
    logic [WORDSIZE-1:0] rsp_result_q, rsp_result_d;
    logic [3:0]          rsp_flags_q, rsp_flags_d;

    logic [1:0]          req_ready_c;
    logic [1:0]          rsp_valid_c;
    logic                grant_sel;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_funct3_d = alu_funct3_q;
        alu_funct7_d = alu_funct7_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        req_ready_c  = 2'b00;
        rsp_valid_c  = 2'b00;
        grant_sel    = 1'b0;

        case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    // On a tie the requester that did not win last time goes first.
                    grant_sel              = (&bus.req_valid) ? ~last_grant_q : bus.req_valid[1];
                    req_ready_c[grant_sel] = 1'b1;
                    alu_a_d                = grant_sel ? bus.req_a1 : bus.req_a0;
                    alu_b_d                = grant_sel ? bus.req_b1 : bus.req_b0;
                    alu_funct3_d           = grant_sel ? bus.req_funct3[5:3] : bus.req_funct3[2:0];
                    alu_funct7_d           = bus.req_funct7[grant_sel];
                    grant_id_d             = grant_sel;
                    state_d                = EXEC;
                end
            end
            EXEC: begin
                rsp_result_d = bus.alu_result;
                rsp_flags_d  = bus.alu_flags;
                state_d      = RESP;
            end
            RESP: begin
                rsp_valid_c[grant_id_q] = 1'b1;
                if (bus.rsp_ready[grant_id_q]) begin
                    last_grant_d = grant_id_q;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_funct3_q <= 3'd0;
            alu_funct7_q <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= 4'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_funct3_q <= alu_funct3_d;
            alu_funct7_q <= alu_funct7_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
        end
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.rsp_valid  = rsp_valid_c;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_funct3 = alu_funct3_q;
    assign bus.alu_funct7 = alu_funct7_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_flags  = rsp_flags_q;
    assign bus.busy       = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Directed bench for alu_arbiter with a behavioural ALU and a
//               grant-ordered scoreboard of expected responses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_alu_arbiter;

    typedef struct {
        logic        id;
        logic [63:0] res;
        logic [3:0]  flg;
    } exp_t;

    logic clk;
    logic rst_n;
    logic extra_knob;
    int   n_cmp;
    int   n_err;
    exp_t sb[$];
    bit   grants[$];

    alu_arbiter_if #(.WORDSIZE(64)) bus ();

    alu_arbiter #(.WORDSIZE(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: add/sub, xor, or, and; extra flag is a bench-controlled bit.
    function automatic logic [67:0] alu_f(input logic [63:0] a, input logic [63:0] b,
                                          input logic [2:0] f3, input logic f7, input logic ex);
        logic [63:0] r;
        logic        ov;
        ov = 1'b0;
        case (f3)
            3'd4:    r = a ^ b;
            3'd6:    r = a | b;
            3'd7:    r = a & b;
            default: begin
                if (f7) begin
                    r  = a - b;
                    ov = (a[63] != b[63]) && (r[63] != a[63]);
                end else begin
                    r  = a + b;
                    ov = (a[63] == b[63]) && (r[63] != a[63]);
                end
            end
        endcase
        return {ex, ov, r[63], (r == 64'd0), r};
    endfunction

    always_comb {bus.alu_flags, bus.alu_result} =
        alu_f(bus.alu_a, bus.alu_b, bus.alu_funct3, bus.alu_funct7, extra_knob);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int r, input logic [63:0] a, input logic [63:0] b,
                           input logic [2:0] f3, input logic f7);
        if (r == 0) begin
            bus.req_a0 = a;
            bus.req_b0 = b;
        end else begin
            bus.req_a1 = a;
            bus.req_b1 = b;
        end
        bus.req_funct3[3*r +: 3] = f3;
        bus.req_funct7[r]        = f7;
    endtask

    // Observe one cycle: record grants into the scoreboard, retire responses.
    task automatic step();
        exp_t e;
        exp_t got;
        logic g;
        #1;
        if (bus.req_ready != 2'b00) begin
            g = bus.req_ready[1];
            chk("grant_onehot", 64'($countones(bus.req_ready)), 64'd1);
            grants.push_back(g);
            e.id = g;
            if (g)
                {e.flg, e.res} = alu_f(bus.req_a1, bus.req_b1, bus.req_funct3[5:3], bus.req_funct7[1], extra_knob);
            else
                {e.flg, e.res} = alu_f(bus.req_a0, bus.req_b0, bus.req_funct3[2:0], bus.req_funct7[0], extra_knob);
            sb.push_back(e);
        end
        if ((bus.rsp_valid & bus.rsp_ready) != 2'b00) begin
            chk("rsp_has_pending", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                got = sb.pop_front();
                chk("rsp_valid_onehot", 64'($countones(bus.rsp_valid)), 64'd1);
                chk("rsp_id", 64'(bus.rsp_valid[1]), 64'(got.id));
                chk("rsp_result", bus.rsp_result, got.res);
                chk("rsp_flags", 64'(bus.rsp_flags), 64'(got.flg));
            end
        end
        @(negedge clk);
    endtask

    function automatic int count_r1();
        int n;
        n = 0;
        foreach (grants[i]) if (grants[i]) n++;
        return n;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n1;
        n_cmp          = 0;
        n_err          = 0;
        rst_n          = 1'b0;
        extra_knob     = 1'b1;
        bus.req_valid  = 2'b00;
        bus.rsp_ready  = 2'b00;
        bus.req_funct3 = 6'd0;
        bus.req_funct7 = 2'b00;
        set_req(0, 64'd0, 64'd0, 3'd0, 1'b0);
        set_req(1, 64'd0, 64'd0, 3'd0, 1'b0);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_alu_a", bus.alu_a, 64'd0);
        chk("rst_alu_b", bus.alu_b, 64'd0);
        chk("rst_alu_funct3", 64'(bus.alu_funct3), 64'd0);
        chk("rst_alu_funct7", 64'(bus.alu_funct7), 64'd0);
        chk("rst_rsp_result", bus.rsp_result, 64'd0);
        chk("rst_rsp_flags", 64'(bus.rsp_flags), 64'd0);
        rst_n = 1'b1;
        step();

        // Simultaneous held requests: r0 first, then strict alternation
        grants.delete();
        extra_knob = 1'b0;
        set_req(0, 64'd100, 64'd3, 3'd0, 1'b1);
        set_req(1, 64'hFF00, 64'h0F0F, 3'd7, 1'b0);
        bus.rsp_ready = 2'b11;
        bus.req_valid = 2'b11;
        #1;
        chk("rr_first_grant", 64'(bus.req_ready), 64'b01);
        repeat (12) step();
        bus.req_valid = 2'b00;
        chk("rr_num_grants", 64'(grants.size()), 64'd4);
        for (int i = 0; i < grants.size() && i < 4; i++)
            chk("rr_grant_order", 64'(grants[i]), 64'(i % 2));
        chk("rr_sb_drained", 64'(sb.size()), 64'd0);
        extra_knob = 1'b1;
        step();

        // Single request from r0: 5 + 7
        set_req(0, 64'd5, 64'd7, 3'd0, 1'b0);
        bus.req_valid = 2'b01;
        #1;
        chk("single_req_ready", 64'(bus.req_ready), 64'b01);
        step();
        bus.req_valid = 2'b00;
        #1;
        chk("single_ready_drop", 64'(bus.req_ready), 64'd0);
        chk("single_busy", 64'(bus.busy), 64'd1);
        chk("single_alu_a", bus.alu_a, 64'd5);
        chk("single_alu_b", bus.alu_b, 64'd7);
        chk("single_exec_no_rsp", 64'(bus.rsp_valid), 64'd0);
        step();
        #1;
        chk("single_rsp_valid", 64'(bus.rsp_valid), 64'b01);
        chk("single_result", bus.rsp_result, 64'd12);
        chk("single_flags", 64'(bus.rsp_flags), 64'b1000);
        step();
        #1;
        chk("single_idle", 64'(bus.busy), 64'd0);
        step();

        // Overflow passthrough on r1
        set_req(1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'd0, 1'b0);
        bus.req_valid = 2'b10;
        #1;
        chk("ovf_req_ready", 64'(bus.req_ready), 64'b10);
        step();
        bus.req_valid = 2'b00;
        step();
        #1;
        chk("ovf_rsp_valid", 64'(bus.rsp_valid), 64'b10);
        chk("ovf_flags", 64'(bus.rsp_flags), 64'b1110);
        chk("ovf_result", bus.rsp_result, 64'h8000_0000_0000_0000);
        step();

        // Backpressure on r0 while r1 waits; rsp_ready[1] must be ignored
        set_req(0, 64'h1234, 64'h1111, 3'd4, 1'b0);
        set_req(1, 64'd9, 64'd4, 3'd0, 1'b1);
        bus.rsp_ready = 2'b10;
        bus.req_valid = 2'b11;
        #1;
        chk("bp_grant_r0", 64'(bus.req_ready), 64'b01);
        step();
        bus.req_valid = 2'b10;
        step();
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("bp_busy", 64'(bus.busy), 64'd1);
            chk("bp_no_grant", 64'(bus.req_ready), 64'd0);
            chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'b01);
            chk("bp_result_stable", bus.rsp_result, 64'h0325);
            step();
        end
        bus.rsp_ready = 2'b11;
        step();
        #1;
        chk("bp_r1_granted", 64'(bus.req_ready), 64'b10);
        step();
        bus.req_valid = 2'b00;
        step();
        #1;
        chk("bp_r1_rsp_valid", 64'(bus.rsp_valid), 64'b10);
        chk("bp_r1_result", bus.rsp_result, 64'd5);
        step();

        // r1 pulses req_valid for one cycle during RESP, then withdraws
        n1 = count_r1();
        set_req(0, 64'd42, 64'd8, 3'd6, 1'b0);
        bus.rsp_ready = 2'b00;
        bus.req_valid = 2'b01;
        step();
        bus.req_valid = 2'b00;
        step();
        bus.req_valid = 2'b10;
        #1;
        chk("wd_no_grant_in_resp", 64'(bus.req_ready), 64'd0);
        chk("wd_rsp_valid", 64'(bus.rsp_valid), 64'b01);
        step();
        bus.req_valid = 2'b00;
        step();
        bus.rsp_ready = 2'b01;
        step();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("wd_no_rsp", 64'(bus.rsp_valid), 64'd0);
            chk("wd_idle", 64'(bus.busy), 64'd0);
            step();
        end
        chk("wd_r1_grants", 64'(count_r1()), 64'(n1));

        // Asynchronous reset while in EXEC
        set_req(1, 64'hABC, 64'd1, 3'd0, 1'b0);
        bus.rsp_ready = 2'b11;
        bus.req_valid = 2'b10;
        step();
        bus.req_valid = 2'b00;
        #1;
        chk("mr_alu_a_loaded", bus.alu_a, 64'hABC);
        rst_n = 1'b0;
        #1;
        chk("mr_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("mr_alu_a", bus.alu_a, 64'd0);
        chk("mr_busy", 64'(bus.busy), 64'd0);
        chk("mr_rsp_result", bus.rsp_result, 64'd0);
        sb.delete();
        step();
        step();
        rst_n = 1'b1;
        step();
        set_req(0, 64'd20, 64'd22, 3'd0, 1'b0);
        bus.req_valid = 2'b11;
        #1;
        chk("mr_grant_r0", 64'(bus.req_ready), 64'b01);
        step();
        bus.req_valid = 2'b00;
        step();
        #1;
        chk("mr_rsp_valid_r0", 64'(bus.rsp_valid), 64'b01);
        chk("mr_result", bus.rsp_result, 64'd42);
        step();
        step();

        chk("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 64-bit ALU and its flag generator between two requesters, e.g. the execute stage and the address/branch unit. Each requester presents operands and an operation code over a valid/ready handshake. The block grants requesters round-robin and drives the registered operands onto the ALU. It captures the ALU result and the 4-bit flag vector, then returns them to the granted requester over its own valid/ready response port.

## Interface
- WORDSIZE, 64, data width of operands and result

Ports (index [0]/[1] selects requester 0/1):
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  2  request present, per requester
- req_ready  out  2  request accepted this cycle, per requester
- req_a0, req_a1  in  WORDSIZE  first operand
- req_b0, req_b1  in  WORDSIZE  second operand
- req_funct3  in  2x3  operation select, packed {r1, r0}
- req_funct7  in  2  operation modifier bit (0 = add/normal, 1 = sub/alternate)
- alu_a, alu_b  out  WORDSIZE  registered operands to the ALU
- alu_funct3  out  3  registered operation select to the ALU
- alu_funct7  out  1  registered modifier to the ALU
- alu_result  in  WORDSIZE  combinational ALU result
- alu_flags  in  4  combinational flags {extra, overflow, msb, zero}
- rsp_valid  out  2  response present, per requester
- rsp_ready  in  2  response consumed, per requester
- rsp_result  out  WORDSIZE  captured result, shared by both response ports
- rsp_flags  out  4  captured flags, same bit order as alu_flags
- busy  out  1  high whenever the FSM is not in IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE, no req_valid: stay in IDLE; req_ready = 0.
- IDLE, one requester valid: grant that requester.
- IDLE, both requesters valid: grant the requester that is not last_grant.
- On a grant:
  - req_ready[g] = 1 combinationally in the same cycle; at most one bit is ever high.
  - The granted operands, funct3 and funct7 are loaded into alu_*.
  - grant_id <= g; next state is EXEC.
- EXEC (exactly 1 cycle):
  - alu_* hold their values.
  - rsp_result <= alu_result and rsp_flags <= alu_flags at the clock edge.
  - Next state is RESP.
- RESP:
  - rsp_valid[grant_id] = 1; the other rsp_valid bit is 0.
  - When rsp_ready[grant_id] = 1: last_grant <= grant_id and next state is IDLE.
  - rsp_ready on the non-granted index is ignored.
- Flags pass through unmodified. The block never recomputes or masks flag bits.
- alu_* hold their last values outside EXEC; they change only on a grant.
- A requester may drop req_valid before it is granted. No transaction is created.
- A requester must hold its operands stable only in the cycle where req_ready is high.

## Timing
- Reset values: state = IDLE, last_grant = 1 (requester 0 wins first), grant_id = 0, req_ready = 0, rsp_valid = 0, busy = 0; alu_a, alu_b, alu_funct3, alu_funct7, rsp_result and rsp_flags are all zero.
- Latency: a request accepted at edge N has alu_* valid after edge N.
  - rsp_result is captured at edge N+1.
  - rsp_valid is high from edge N+1 onward.
- Throughput: one operation per 3 cycles when rsp_ready is held high.
  - The new grant is in the IDLE cycle after the response handshake; there is no IDLE-to-IDLE bypass.
- Backpressure: RESP holds indefinitely with rsp_result and rsp_flags stable. No new grant is issued while in RESP.
- Arbitration is decided only in IDLE. Requests arriving during EXEC or RESP wait.
- Reset mid-operation (EXEC or RESP):
  - The transaction is dropped and no response is issued.
  - All outputs return to their reset values immediately, since the reset is asynchronous.
- No combinational path from rsp_ready to req_ready within the same cycle.

## Test plan
- Single request: r0 sends a=5, b=7, funct3=0, funct7=0; the ALU model returns 12 with flags 4'b1000. Required: req_ready[0] is high for 1 cycle, rsp_valid[0] rises 2 edges later, rsp_result = 12, rsp_flags = 4'b1000.
- Simultaneous requests after reset: both requesters valid and held. Required: r0 is granted first, then r1; grants continue to alternate 0,1,0,1 over 4 operations.
- Overflow passthrough: r1 sends a = 64'h7FFF_FFFF_FFFF_FFFF, b = 1, funct7 = 0; the ALU returns 64'h8000_0000_0000_0000 with flags 4'b1110. Required: rsp_flags = 4'b1110 and only rsp_valid[1] is high.
- Backpressure: rsp_ready[0] is held low for 10 cycles while r1 is valid. Required: rsp_result is stable, busy = 1, req_ready[1] stays 0, and r1 is granted in the IDLE cycle after the handshake.
- Mid-operation reset: rst_n is pulsed low during EXEC. Required: rsp_valid = 0, alu_a = 0 and busy = 0 immediately; the next request is granted to r0.
- Request withdrawal: r1 asserts req_valid for 1 cycle while the block is in RESP, then drops it. Required: no r1 transaction ever occurs and no rsp_valid[1] appears.
